// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for the 5-stage core. It detects load-use
//   hazards and stalls for 1+LOAD_EXTRA cycles. It freezes the whole pipe
//   while data memory is busy, and flushes F/D and D/E on a taken branch
//   or jump. It also drives the E-stage forwarding selects and a
//   saturating count of stalled cycles.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   IDLE      | normal flow; a load-use hit costs one bubble here
//   LOAD_WAIT | extra load bubbles; cnt holds bubbles still owed
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rs1_d, rs2_d, use_rs*_d       D-stage sources and their read qualifiers
//   rs1_e, rs2_e, rd_e            E-stage sources and destination
//   is_load_e, pc_src_e           E instr is a load / redirect resolved in E
//   rd_m, reg_write_m             M-stage destination and write enable
//   mem_req_m, dmem_ready         M-stage data access and its completion
//   rd_w, reg_write_w             W-stage destination and write enable
//   pc_en, f_en, d_en, e_en, m_en pipeline register enables
//   flush_d, flush_e              clear F/D, clear D/E
//   fwd_a_e, fwd_b_e              ALU operand selects (00 rf, 01 W, 10 M)
//   stall_cnt                     saturating count of cycles with pc_en=0
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_EXTRA = 0,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              is_load_e,
    input  logic              pc_src_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic              mem_req_m,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output logic              pc_en,
    output logic              f_en,
    output logic              d_en,
    output logic              e_en,
    output logic              m_en,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    localparam logic [3:0] EXTRA = 4'(LOAD_EXTRA);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lu_hit;
    logic       mem_stall;

    assign lu_hit = is_load_e && (rd_e != '0) &&
                    (((rd_e == rs1_d) && use_rs1_d) || ((rd_e == rs2_d) && use_rs2_d));
    assign mem_stall = mem_req_m && !dmem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_en   = 1'b1;
        f_en    = 1'b1;
        d_en    = 1'b1;
        e_en    = 1'b1;
        m_en    = 1'b1;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (rst) begin
            // the held instruction is discarded when reset lands mid-stall
            flush_d = 1'b1;
            flush_e = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (mem_stall) begin
            pc_en = 1'b0;
            f_en  = 1'b0;
            d_en  = 1'b0;
            e_en  = 1'b0;
            m_en  = 1'b0;
        end else if (pc_src_e) begin
            // the stalled D instruction is on the wrong path, so drop the stall
            flush_d = 1'b1;
            flush_e = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == LOAD_WAIT) begin
            pc_en   = 1'b0;
            f_en    = 1'b0;
            d_en    = 1'b0;
            flush_e = 1'b1;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (lu_hit) begin
            pc_en   = 1'b0;
            f_en    = 1'b0;
            d_en    = 1'b0;
            flush_e = 1'b1;
            if (LOAD_EXTRA > 0) begin
                state_d = LOAD_WAIT;
                cnt_d   = EXTRA;
            end
        end
    end

    // M result is younger than W, so it wins when both match
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (!rst) begin
            if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
                fwd_a_e = 2'b10;
            else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
                fwd_a_e = 2'b01;
            if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
                fwd_b_e = 2'b10;
            else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
                fwd_b_e = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (!pc_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
